// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM for the multicycle MIPS datapath; drives the
//            ALU-op class and consumes jr/jmadd steering from ALU control.
//            Optional macro ILLEGAL_OP_TRAP_EN adds the TRAP state and the
//            illegal_op output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    op,
    input  logic          jmaddctrl,
    input  logic          jrctrl,
    output logic          aluop1,
    output logic          aluop0,
    output logic          xori,
    output logic          pcwrite,
    output logic          pcwritecond,
    output logic          brgez,
    output logic [1:0]    pcsource,
    output logic          iord,
    output logic          memread,
    output logic          memwrite,
    output logic          irwrite,
    output logic          memtoreg,
    output logic          regwrite,
    output logic [1:0]    regdst,
    output logic          alusrca,
    output logic [1:0]    alusrcb,
    output logic [SW-1:0] state
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic          illegal_op
`endif
);

    localparam logic [SW-1:0] c_FETCH  = SW'(0);
    localparam logic [SW-1:0] c_DECODE = SW'(1);
    localparam logic [SW-1:0] c_MEMADR = SW'(2);
    localparam logic [SW-1:0] c_MEMRD  = SW'(3);
    localparam logic [SW-1:0] c_MEMWB  = SW'(4);
    localparam logic [SW-1:0] c_MEMWR  = SW'(5);
    localparam logic [SW-1:0] c_REXEC  = SW'(6);
    localparam logic [SW-1:0] c_RWB    = SW'(7);
    localparam logic [SW-1:0] c_BEQ    = SW'(8);
    localparam logic [SW-1:0] c_JUMP   = SW'(9);
    localparam logic [SW-1:0] c_XEX    = SW'(10);
    localparam logic [SW-1:0] c_XWB    = SW'(11);
    localparam logic [SW-1:0] c_BGEZ   = SW'(12);
    localparam logic [SW-1:0] c_JMRD   = SW'(13);
    localparam logic [SW-1:0] c_JMWB   = SW'(14);
`ifdef ILLEGAL_OP_TRAP_EN
    localparam logic [SW-1:0] c_TRAP   = SW'(15);
`endif

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_XORI  = 6'b001110;
    localparam logic [5:0] c_OP_BGEZ  = 6'b000001;

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = c_FETCH;
        case (state_q)
            c_FETCH:  state_d = c_DECODE;
            c_DECODE: begin
                case (op)
                    c_OP_RTYPE:       state_d = c_REXEC;
                    c_OP_LW, c_OP_SW: state_d = c_MEMADR;
                    c_OP_BEQ:         state_d = c_BEQ;
                    c_OP_J:           state_d = c_JUMP;
                    c_OP_XORI:        state_d = c_XEX;
                    c_OP_BGEZ:        state_d = c_BGEZ;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:          state_d = c_TRAP;
`else
                    // PC was already advanced in FETCH, so this is a NOP
                    default:          state_d = c_FETCH;
`endif
                endcase
            end
            c_MEMADR: state_d = (op == c_OP_SW) ? c_MEMWR : c_MEMRD;
            c_MEMRD:  state_d = c_MEMWB;
            c_REXEC: begin
                // jr wins if ALU control ever flags both
                if (jrctrl) begin
                    state_d = c_FETCH;
                end else if (jmaddctrl) begin
                    state_d = c_JMRD;
                end else begin
                    state_d = c_RWB;
                end
            end
            c_JMRD:   state_d = c_JMWB;
            c_XEX:    state_d = c_XWB;
`ifdef ILLEGAL_OP_TRAP_EN
            c_TRAP:   state_d = c_TRAP;
`endif
            default:  state_d = c_FETCH;
        endcase
    end

    always_comb begin
        aluop1      = 1'b0;
        aluop0      = 1'b0;
        xori        = 1'b0;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        brgez       = 1'b0;
        pcsource    = 2'b00;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        regdst      = 2'b00;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
`ifdef ILLEGAL_OP_TRAP_EN
        illegal_op  = 1'b0;
`endif
        if (!reset) begin
            case (state_q)
                c_FETCH: begin
                    memread = 1'b1;
                    irwrite = 1'b1;
                    alusrcb = 2'b01;
                    pcwrite = 1'b1;
                end
                c_DECODE: alusrcb = 2'b11;
                c_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                c_MEMRD, c_JMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                c_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                c_MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                c_REXEC: begin
                    alusrca  = 1'b1;
                    aluop1   = 1'b1;
                    pcwrite  = jrctrl;
                    pcsource = {jrctrl, jrctrl};
                end
                c_RWB: begin
                    regwrite = 1'b1;
                    regdst   = 2'b01;
                    aluop1   = 1'b1;
                end
                c_JMWB: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b11;
                    regwrite = 1'b1;
                    regdst   = 2'b10;
                end
                c_BEQ: begin
                    alusrca     = 1'b1;
                    aluop0      = 1'b1;
                    pcwritecond = 1'b1;
                    pcsource    = 2'b01;
                end
                c_BGEZ: begin
                    alusrca     = 1'b1;
                    pcwritecond = 1'b1;
                    brgez       = 1'b1;
                end
                c_JUMP: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b10;
                end
                c_XEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                    xori    = 1'b1;
                end
                c_XWB: begin
                    regwrite = 1'b1;
                    xori     = 1'b1;
                end
`ifdef ILLEGAL_OP_TRAP_EN
                c_TRAP: illegal_op = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign state = reset ? '0 : state_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench for multicycle_control against an
//            instruction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

    typedef int q_t[$];

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       jmaddctrl;
    logic       jrctrl;
    logic       aluop1, aluop0, xori, pcwrite, pcwritecond, brgez;
    logic [1:0] pcsource;
    logic       iord, memread, memwrite, irwrite, memtoreg, regwrite;
    logic [1:0] regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control #(.SW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .jmaddctrl   (jmaddctrl),
        .jrctrl      (jrctrl),
        .aluop1      (aluop1),
        .aluop0      (aluop0),
        .xori        (xori),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .brgez       (brgez),
        .pcsource    (pcsource),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .memtoreg    (memtoreg),
        .regwrite    (regwrite),
        .regdst      (regdst),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .state       (state)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .illegal_op  (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    // Packing order: aluop1 aluop0 xori pcwrite pcwritecond brgez pcsource
    // iord memread memwrite irwrite memtoreg regwrite regdst alusrca alusrcb
    function automatic logic [18:0] pack(
        bit a1, bit a0, bit xo, bit pw, bit pwc, bit bg, logic [1:0] ps,
        bit io, bit mr, bit mw, bit ir, bit mtr, bit rw, logic [1:0] rd,
        bit sa, logic [1:0] sb);
        return {a1, a0, xo, pw, pwc, bg, ps, io, mr, mw, ir, mtr, rw, rd, sa, sb};
    endfunction

    function automatic logic [18:0] observed();
        return {aluop1, aluop0, xori, pcwrite, pcwritecond, brgez, pcsource,
                iord, memread, memwrite, irwrite, memtoreg, regwrite, regdst,
                alusrca, alusrcb};
    endfunction

    // Control word the datapath needs for each named step of an instruction
    function automatic logic [18:0] step_word(int s, bit jr);
        case (s)
            0:  return pack(0,0,0,1,0,0,2'b00, 0,1,0,1,0,0,2'b00, 0,2'b01);
            1:  return pack(0,0,0,0,0,0,2'b00, 0,0,0,0,0,0,2'b00, 0,2'b11);
            2:  return pack(0,0,0,0,0,0,2'b00, 0,0,0,0,0,0,2'b00, 1,2'b10);
            3:  return pack(0,0,0,0,0,0,2'b00, 1,1,0,0,0,0,2'b00, 0,2'b00);
            4:  return pack(0,0,0,0,0,0,2'b00, 0,0,0,0,1,1,2'b00, 0,2'b00);
            5:  return pack(0,0,0,0,0,0,2'b00, 1,0,1,0,0,0,2'b00, 0,2'b00);
            6:  return pack(1,0,0,jr,0,0,jr ? 2'b11 : 2'b00, 0,0,0,0,0,0,2'b00, 1,2'b00);
            7:  return pack(1,0,0,0,0,0,2'b00, 0,0,0,0,0,1,2'b01, 0,2'b00);
            8:  return pack(0,1,0,0,1,0,2'b01, 0,0,0,0,0,0,2'b00, 1,2'b00);
            9:  return pack(0,0,0,1,0,0,2'b10, 0,0,0,0,0,0,2'b00, 0,2'b00);
            10: return pack(0,0,1,0,0,0,2'b00, 0,0,0,0,0,0,2'b00, 1,2'b10);
            11: return pack(0,0,1,0,0,0,2'b00, 0,0,0,0,0,1,2'b00, 0,2'b00);
            12: return pack(0,0,0,0,1,1,2'b00, 0,0,0,0,0,0,2'b00, 1,2'b00);
            13: return pack(0,0,0,0,0,0,2'b00, 1,1,0,0,0,0,2'b00, 0,2'b00);
            14: return pack(0,0,0,1,0,0,2'b11, 0,0,0,0,0,1,2'b10, 0,2'b00);
            default: return '0;
        endcase
    endfunction

    // Sequence of steps an instruction walks through, starting at FETCH
    function automatic q_t steps_for(logic [5:0] o, bit jr, bit jm);
        case (o)
            6'b100011: return '{0, 1, 2, 3, 4};
            6'b101011: return '{0, 1, 2, 5};
            6'b000000: begin
                if (jr)      return '{0, 1, 6};
                else if (jm) return '{0, 1, 6, 13, 14};
                else         return '{0, 1, 6, 7};
            end
            6'b000100: return '{0, 1, 8};
            6'b000010: return '{0, 1, 9};
            6'b001110: return '{0, 1, 10, 11};
            6'b000001: return '{0, 1, 12};
            default:   return '{0, 1};
        endcase
    endfunction

    function automatic bit is_legal(logic [5:0] o);
        return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                         6'b000010, 6'b001110, 6'b000001};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_step(input int s, input bit jr);
        chk("state", 32'(state), 32'(s));
        chk("ctrl", 32'(observed()), 32'(step_word(s, jr)));
        chk("mem_excl", 32'(memread & memwrite), 32'd0);
`ifdef ILLEGAL_OP_TRAP_EN
        chk("illegal_op", 32'(illegal_op), 32'(s == 15));
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input bit jr, input bit jm);
        q_t seq;
        op        = o;
        jrctrl    = jr;
        jmaddctrl = jm;
        seq = steps_for(o, jr, jm);
        foreach (seq[i]) begin
            check_step(seq[i], jr);
            advance();
        end
        chk("end_fetch", 32'(state), 32'd0);
    endtask

    initial begin
        logic [5:0] rop;
        logic [5:0] legal_ops [7];
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b000010, 6'b001110, 6'b000001};
        reset     = 1'b1;
        op        = 6'b100011;
        jrctrl    = 1'b1;
        jmaddctrl = 1'b1;

        repeat (2) begin
            advance();
            chk("rst_state", 32'(state), 32'd0);
            chk("rst_ctrl", 32'(observed()), 32'd0);
        end
        reset = 1'b0;
        #1;

        // Directed: lw, R add, jr, jmadd, both flags, xori, bgez, beq, j, sw, unknown
        run_instr(6'b100011, 1'b0, 1'b0);
        run_instr(6'b000000, 1'b0, 1'b0);
        run_instr(6'b000000, 1'b1, 1'b0);
        run_instr(6'b000000, 1'b0, 1'b1);
        run_instr(6'b000000, 1'b1, 1'b1);
        run_instr(6'b001110, 1'b0, 1'b0);
        run_instr(6'b000001, 1'b0, 1'b0);
        run_instr(6'b000100, 1'b0, 1'b0);
        run_instr(6'b000010, 1'b0, 1'b0);
        run_instr(6'b101011, 1'b0, 1'b0);
`ifndef ILLEGAL_OP_TRAP_EN
        run_instr(6'b111111, 1'b0, 1'b0);
`endif

        // Reset arriving in the middle of a store
        op = 6'b101011; jrctrl = 1'b0; jmaddctrl = 1'b0;
        check_step(0, 1'b0); advance();
        check_step(1, 1'b0); advance();
        check_step(2, 1'b0); advance();
        check_step(5, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_memwrite", 32'(memwrite), 32'd0);
        chk("midrst_ctrl", 32'(observed()), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        advance();
        reset = 1'b0;
        #1;
        check_step(0, 1'b0);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
`ifdef ILLEGAL_OP_TRAP_EN
                rop = legal_ops[$urandom_range(0, 6)];
`else
                do rop = 6'($urandom); while (is_legal(rop));
`endif
            end else begin
                rop = legal_ops[$urandom_range(0, 6)];
            end
            run_instr(rop, 1'($urandom), 1'($urandom));
        end

`ifdef ILLEGAL_OP_TRAP_EN
        op = 6'b111111; jrctrl = 1'b0; jmaddctrl = 1'b0;
        check_step(0, 1'b0); advance();
        check_step(1, 1'b0); advance();
        repeat (3) begin
            check_step(15, 1'b0);
            advance();
        end
        reset = 1'b1;
        #1;
        chk("trap_rst_illegal", 32'(illegal_op), 32'd0);
        advance();
        reset = 1'b0;
        #1;
        run_instr(6'b100011, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
